// File: rtl/execute_cross4_node_mix_drain_if.sv
// Bundle of control, RAM port-1 and output-stream signals for the drain stage.
//   master : controller / RAM / stream sink side (drives ap_start, len, mem_q1, out_ready)
//   slave  : the drain stage itself (drives status, RAM read address/enable, stream outputs)
interface execute_cross4_node_mix_drain_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 6
);
  logic                    ap_start;
  logic [AddressWidth-1:0] len;
  logic                    ap_idle;
  logic                    ap_ready;
  logic                    ap_done;
  logic [AddressWidth-1:0] mem_address1;
  logic                    mem_ce1;
  logic [DataWidth-1:0]    mem_q1;
  logic [DataWidth-1:0]    out_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    out_ready;

  modport master (
    output ap_start, len, mem_q1, out_ready,
    input  ap_idle, ap_ready, ap_done, mem_address1, mem_ce1,
           out_data, out_valid, out_last
  );

  modport slave (
    input  ap_start, len, mem_q1, out_ready,
    output ap_idle, ap_ready, ap_done, mem_address1, mem_ce1,
           out_data, out_valid, out_last
  );
endinterface

// File: rtl/execute_cross4_node_mix_drain.sv
// Read-side streaming stage for the execute_cross4_node_mix_array_0 RAM.
// Reads words 0..L-1 through RAM port 1 (one-cycle read latency) and emits
// them on a valid/ready stream with a last flag, L = min(len, MemSize).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control (ap_start/len/ap_idle/ap_ready/ap_done), RAM port 1
//           (mem_address1/mem_ce1/mem_q1) and stream (out_*) signals
//
// state | meaning
// IDLE  | waiting for ap_start; ap_idle high
// RUN   | issuing reads, draining the 2-entry output FIFO
// DONE  | one-cycle ap_done pulse, then back to IDLE
module execute_cross4_node_mix_drain #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 6,
  parameter int MemSize      = 33
) (
  input  logic                          clk,
  input  logic                          reset,
  execute_cross4_node_mix_drain_if.slave bus
);

  // One extra bit so rd_idx can reach L even when MemSize == 2**AddressWidth.
  localparam int CW = AddressWidth + 1;
  localparam logic [CW-1:0] MEM_WORDS = CW'(MemSize);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        len_q;
  logic [CW-1:0]        rd_idx_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic [DataWidth-1:0] fifo_data_q [2];
  logic [1:0]           fifo_last_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           occ_q;

  logic [CW-1:0] len_ext;
  logic [CW-1:0] len_clamped;
  logic          out_valid;
  logic          out_last;
  logic          pop;
  logic          push;
  logic          issue;
  logic          start_accept;
  logic          ap_idle;
  logic          ap_ready;
  logic          ap_done;

  assign len_ext     = {1'b0, bus.len};
  assign len_clamped = (len_ext > MEM_WORDS) ? MEM_WORDS : len_ext;

  assign out_valid = (occ_q != 2'd0);
  assign out_last  = fifo_last_q[rd_ptr_q];
  assign pop       = out_valid & bus.out_ready;
  assign push      = inflight_q;

  // Credit: words in flight plus words buffered, less the one leaving this
  // cycle, must stay below the FIFO depth so a capture always has a slot.
  assign issue = (state_q == S_RUN) && (rd_idx_q < len_q) &&
                 (({2'b00, inflight_q} + {1'b0, occ_q}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ap_idle      = 1'b0;
    ap_ready     = 1'b0;
    ap_done      = 1'b0;
    start_accept = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (bus.ap_start) begin
          ap_ready     = 1'b1;
          start_accept = 1'b1;
          state_d      = (len_clamped == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE: begin
        ap_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q           <= '0;
      rd_idx_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      occ_q           <= '0;
    end else begin
      if (start_accept) begin
        len_q    <= len_clamped;
        rd_idx_q <= '0;
      end else if (issue) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end

      // The last flag is decided at issue time so the capture side only
      // has to carry one bit alongside the read.
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_idx_q == len_q - 1'b1);

      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.mem_q1;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign bus.ap_idle      = ap_idle;
  assign bus.ap_ready     = ap_ready;
  assign bus.ap_done      = ap_done;
  assign bus.mem_address1 = rd_idx_q[AddressWidth-1:0];
  assign bus.mem_ce1      = issue;
  assign bus.out_data     = fifo_data_q[rd_ptr_q];
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;

endmodule

// File: tb/tb_execute_cross4_node_mix_drain.sv
// Bench for execute_cross4_node_mix_drain: behavioural RAM, expected-word
// queue per transfer, randomized contents/lengths/backpressure.
module tb_execute_cross4_node_mix_drain;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int MS = 33;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] ram [MS];

  execute_cross4_node_mix_drain_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

  execute_cross4_node_mix_drain #(
    .DataWidth(DW), .AddressWidth(AW), .MemSize(MS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_ce1) begin
      if (int'(bus.mem_address1) < MS) bus.mem_q1 <= ram[bus.mem_address1];
      else                             bus.mem_q1 <= 32'hdead_beef;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_idle"},  bus.ap_idle,      1);
    chk({tag, "_ready"}, bus.ap_ready,     0);
    chk({tag, "_done"},  bus.ap_done,      0);
    chk({tag, "_ce"},    bus.mem_ce1,      0);
    chk({tag, "_addr"},  bus.mem_address1, 0);
    chk({tag, "_valid"}, bus.out_valid,    0);
    chk({tag, "_last"},  bus.out_last,     0);
    chk({tag, "_data"},  bus.out_data,     0);
  endtask

  // mode 0: out_ready always 1; mode 1: 1-on/2-off; mode 2: random.
  // hold keeps ap_start high throughout; pulse_mid raises it in cycle 2 only;
  // abort_cyc > 0 asserts reset in that cycle and abandons the transfer.
  task automatic run_xfer(input int n, input int mode, input bit hold,
                          input bit pulse_mid, input int abort_cyc);
    int L, issued, popped, cyc, done_cyc, first_valid, last_pop_cyc;
    bit stalled;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic [DW-1:0] exp_d [$];
    bit exp_l [$];
    L = (n > MS) ? MS : n;
    for (int i = 0; i < L; i++) begin
      exp_d.push_back(ram[i]);
      exp_l.push_back(i == L - 1);
    end
    issued = 0; popped = 0; done_cyc = -1; first_valid = -1; last_pop_cyc = -1;
    stalled = 0; prev_data = '0; prev_last = 0;

    @(negedge clk);
    bus.ap_start  = 1'b1;
    bus.len       = n[AW-1:0];
    bus.out_ready = 1'b1;
    #1;
    chk("start_idle",  bus.ap_idle,  1);
    chk("start_ready", bus.ap_ready, 1);
    chk("start_ce",    bus.mem_ce1,  0);

    @(negedge clk);
    cyc = 1;
    while (1) begin
      if (!hold) bus.ap_start = pulse_mid && (cyc == 2);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((cyc % 3) == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == abort_cyc) begin
        reset = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("abort_held");
        reset = 1'b1;
        return;
      end
      chk("run_ready_low", bus.ap_ready, 0);
      chk("run_idle_low",  bus.ap_idle,  0);
      if (bus.mem_ce1) begin
        chk("rd_addr",     bus.mem_address1, issued);
        chk("rd_in_range", int'(bus.mem_address1) < L, 1);
        issued++;
      end
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data",  bus.out_data,  prev_data);
        chk("stall_last",  bus.out_last,  prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (popped < L) begin
          chk("word_data", bus.out_data, exp_d[popped]);
          chk("word_last", bus.out_last, exp_l[popped]);
        end else begin
          chk("extra_word", 0, 1);
        end
        if (popped == 0) first_valid = cyc;
        last_pop_cyc = cyc;
        popped++;
      end
      chk("outstanding_le2", (issued - popped) <= 2, 1);
      stalled   = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (bus.ap_done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > 400) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      cyc++;
    end

    chk("n_reads", issued, L);
    chk("n_words", popped, L);
    if (L == 0) chk("done_cyc_empty", done_cyc, 1);
    else        chk("done_after_last", done_cyc, last_pop_cyc + 1);
    if (mode == 0 && L > 0) begin
      chk("first_valid_cyc", first_valid, 3);
      chk("done_cyc",        done_cyc,    L + 3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.ap_start  = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b0;
    bus.mem_q1    = '0;
    for (int i = 0; i < MS; i++) ram[i] = 32'h1000 + i;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b1;

    run_xfer(4,  0, 0, 0, -1);
    run_xfer(40, 0, 0, 0, -1);
    run_xfer(8,  1, 0, 0, -1);
    run_xfer(0,  0, 0, 0, -1);
    run_xfer(2,  0, 1, 0, -1);
    run_xfer(2,  0, 0, 0, -1);
    run_xfer(6,  0, 0, 1, -1);
    run_xfer(10, 0, 0, 0, 5);
    run_xfer(3,  0, 0, 0, -1);

    for (int i = 0; i < MS; i++) ram[i] = $urandom;
    for (int t = 0; t < 8; t++) run_xfer($urandom_range(0, 63), 2, 0, 0, -1);
    run_xfer(63, 1, 0, 0, -1);

    @(negedge clk);
    #1;
    chk("final_idle", bus.ap_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/execute_cross4_node_mix_drain.md
# execute_cross4_node_mix_drain

Read-side streaming stage for the `execute_cross4_node_mix_array_0` dual-port RAM. It connects to the RAM's read-only port 1 and reads words 0..len-1 in address order, taking the RAM's one-cycle read latency into account. It emits the words on a valid/ready output stream with a last flag. Control uses a start/done/idle/ready handshake so the block can follow the producer stage that fills the array through port 0.

## Interface
- DataWidth, 32, word width; matches the RAM `DataWidth`
- AddressWidth, 6, RAM address width
- MemSize, 33, number of valid RAM words; transfer length is clamped to this value
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset; assertion (0) clears all state immediately
- ap_start  in  1  transfer request; sampled only in IDLE
- len  in  AddressWidth  word count; latched when a start is accepted
- ap_idle  out  1  high in IDLE; reset value 1
- ap_ready  out  1  one-cycle pulse when a start is accepted; reset value 0
- ap_done  out  1  one-cycle pulse when a transfer completes; reset value 0
- mem_address1  out  AddressWidth  RAM port-1 read address; reset value 0
- mem_ce1  out  1  RAM port-1 read enable; reset value 0
- mem_q1  in  DataWidth  RAM port-1 read data; valid the cycle after `mem_ce1`
- out_data  out  DataWidth  stream data; reset value 0
- out_valid  out  1  stream valid; reset value 0
- out_last  out  1  high with the final word of a transfer; reset value 0
- out_ready  in  1  downstream accept

## Operation
- FSM states:
  - IDLE: if ap_start=1, latch L = min(len, MemSize), pulse ap_ready, and go to RUN. If L=0, go directly to DONE instead.
  - RUN: issue reads and drain the FIFO. Go to DONE on the cycle the last word handshakes (out_valid & out_ready & out_last).
  - DONE: pulse ap_done for one cycle, then go to IDLE.
- Read issue:
  - Counter `rd_idx` starts at 0.
  - mem_ce1 = (state==RUN) & (rd_idx < L) & (inflight + occ − pop < 2).
  - pop = out_valid & out_ready.
  - mem_address1 = rd_idx; rd_idx increments on each issued read.
- In-flight tracking:
  - `inflight` is a 1-bit register set to mem_ce1.
  - When inflight=1, capture mem_q1 into the FIFO together with last = (captured index == L−1).
- Output buffer:
  - 2-entry FIFO holding data + last.
  - out_valid = (occ != 0). out_data and out_last come from the head entry.
  - The issue credit rule guarantees the FIFO never overflows.
  - Simultaneous capture and pop is allowed; occupancy is unchanged in that case.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays high.
- ap_start outside IDLE is ignored. A held ap_start is accepted on the first IDLE cycle after DONE, so back-to-back transfers have exactly one DONE cycle between them.
- len values above MemSize, up to 2^AddressWidth−1, are clamped to MemSize; addresses ≥ MemSize are never issued.
- The block never drives RAM port 0 and never writes the RAM.
- Reset mid-transfer clears the FSM to IDLE and clears rd_idx, inflight and occ. Any in-flight read data is discarded and all outputs return to their reset values.

## Timing
- Cycle numbering: start is sampled at the edge ending cycle 0.
  - Cycle 1: state=RUN, mem_ce1=1, address 0.
  - Cycle 2: mem_q1 valid.
  - Cycle 3: out_valid=1 with word 0.
- With out_ready held at 1, the block issues one read and emits one word per cycle. For L words, out_valid is high in cycles 3..L+2, out_last is high in cycle L+2, and ap_done pulses in cycle L+3.
- ap_idle is 0 from cycle 1 until the DONE cycle inclusive, and returns to 1 in the cycle after ap_done.
- L=0: ap_ready pulses in cycle 0, ap_done pulses in cycle 1, and mem_ce1 never asserts.
- Under stall, at most 2 words are buffered or in flight. Reads resume in the same cycle a pop frees credit.

## Test plan
- RAM preloaded with word i = 0x1000+i, len=4, out_ready=1 → out_data 0x1000..0x1003 in cycles 3..6; out_last only in cycle 6; ap_done in cycle 7; exactly 4 mem_ce1 pulses.
- len=40 → clamped to 33 words; highest address issued is 32; out_last on word 0x1020.
- len=8 with out_ready toggling in a 1-on/2-off pattern → all 8 words in order with no duplicates; data stable while stalled; occupancy never exceeds 2.
- len=0 → ap_ready in cycle 0, ap_done in cycle 1, no stream output, no RAM reads.
- ap_start held high, len=2 → two transfers separated by exactly one DONE cycle; a pulse of ap_start during RUN is ignored.
- reset pulsed low in cycle 5 of a len=10 transfer → all outputs go to reset values asynchronously; after release the block is idle (ap_idle=1); a new len=3 start streams words 0..2 correctly.
